input_debounce: RTL
===================

// Module: input_debounce
// PURPOSE
//   Input conditioner placed directly upstream of the OneHot sequence FSM.
//   Synchronises a raw asynchronous input (button/switch/pin) into the clk
//   domain, rejects pulses shorter than STABLE_CYCLES, and delivers a clean
//   level (drives the FSM's inp) plus single-cycle rise/fall strobes.
// PARAMETERS
//   SYNC_STAGES    2   synchroniser flop count; legal range >=2
//   STABLE_CYCLES  4   consecutive synced cycles required to accept a new level; >=2
//   CNT_W          3   stability counter width; must satisfy 2**CNT_W > STABLE_CYCLES-1
// PORTS
//   clk          in   1      system clock, rising-edge
//   rst_n        in   1      asynchronous active-low reset
//   raw_in       in   1      unsynchronised input
//   level        out  1      debounced level (to OneHot inp)
//   rise         out  1      1-cycle strobe on accepted 0->1
//   fall         out  1      1-cycle strobe on accepted 1->0
//   glitch_cnt   out  8      rejected-pulse count (only with INPUT_DEBOUNCE_GLITCH_CNT_EN)
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): sync chain=0, state=IDLE_LOW,
//     cnt=0, level=0, rise=0, fall=0, glitch_cnt=0. Reset mid-operation aborts
//     any WAIT state; no strobe is emitted for the aborted transition.
//   - s = last synchroniser flop. All outputs registered.
//   - FSM (4 states): IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
//     IDLE_LOW : s=1 -> WAIT_HIGH, cnt<=1; else stay.
//     WAIT_HIGH: s=0 -> IDLE_LOW (glitch); s=1 & cnt==STABLE_CYCLES-1 ->
//                IDLE_HIGH, level<=1, rise<=1; else cnt<=cnt+1.
//     IDLE_HIGH: s=0 -> WAIT_LOW, cnt<=1; else stay.
//     WAIT_LOW : s=1 -> IDLE_HIGH (glitch); s=0 & cnt==STABLE_CYCLES-1 ->
//                IDLE_LOW, level<=0, fall<=1; else cnt<=cnt+1.
//   - Latency: counting the first edge that samples raw_in at new value as
//     edge 1, level changes and strobe fires at edge SYNC_STAGES+STABLE_CYCLES
//     (edge 6 with defaults). Strobes high exactly one cycle; rise and fall
//     never both high; a strobe always coincides with a level change.
//   - Accepted pulse minimum: raw_in must hold STABLE_CYCLES consecutive
//     synced cycles; shorter pulses leave level/rise/fall untouched.
//   - cnt only advances in WAIT states; never wraps (bounded by compare).
//   - raw_in high at reset release: full debounce applies, then rise fires.
// CONFIGURATION
//   INPUT_DEBOUNCE_GLITCH_CNT_EN defined: glitch_cnt port present; increments
//     by 1 on every WAIT_HIGH->IDLE_LOW or WAIT_LOW->IDLE_HIGH abort;
//     saturates at 8'hFF; reset to 0.
//   Not defined: glitch_cnt port and its counter logic absent entirely;
//     remaining behaviour identical.
// TESTING
//   1 raw_in 0->1 held 10 cycles (defaults) -> level=1 and rise=1 at edge 6,
//     rise=0 at edge 7, fall never asserted.
//   2 raw_in high 2 cycles then low -> level stays 0, no strobes;
//     glitch_cnt=1 (macro on).
//   3 level=1 steady, raw_in 1->0 held 10 cycles -> level=0 and fall=1 at
//     edge 6, single cycle.
//   4 rst_n pulled low while in WAIT_HIGH (cnt=2) -> all outputs 0
//     immediately (async); after release raw_in=1 needs full 6-edge debounce.
//   5 raw_in=1 during and after reset release -> rise fires once, 6 edges
//     after release; level=1 thereafter.
//   6 300 glitches of 1 synced cycle (macro on) -> glitch_cnt=8'hFF, level=0.

Source files
------------

// File: rtl/input_debounce.sv
// Input conditioner: synchronises raw_in, debounces it, and emits a clean level plus rise/fall strobes.
// Optional rejected-pulse counter on glitch_cnt when INPUT_DEBOUNCE_GLITCH_CNT_EN is defined.
module input_debounce #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_in,
    output logic       level,
    output logic       rise,
    output logic       fall
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign s      = sync_q[SYNC_STAGES-1];

    // Debounce FSM: a new level is accepted only after STABLE_CYCLES matching synced samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;
    logic       abort_c;

    // A WAIT state falling back to its idle state is a rejected pulse
    assign abort_c  = ((state_q == WAIT_HIGH) && !s) || ((state_q == WAIT_LOW) && s);
    assign glitch_d = (abort_c && (glitch_q != 8'hFF)) ? glitch_q + 8'd1 : glitch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
